// File: rtl/des_pkg.sv
// Shared definitions for the DES half-block swap datapath.
package des_pkg;

    // Default width of one DES half-block.
    localparam int unsigned DES_HALF_W = 32;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } swap_state_t;

endpackage

// File: rtl/des_skid_buf.sv
// Two-entry skid buffer with a fully registered valid/ready interface.
// MAIN drives the output; SKID absorbs the block that arrives while the
// consumer stalls, so the upstream side keeps one block per cycle.
module des_skid_buf
    import des_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * DES_HALF_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_xfer
);

    swap_state_t       r_state;
    swap_state_t       w_next;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    // CLEAR suppresses both handshakes so a flushed cycle neither
    // captures nor delivers anything.
    assign w_in_xfer  = i_in_valid & r_in_ready & ~i_clear;
    assign w_out_xfer = (r_state != EMPTY) & i_out_ready & ~i_clear;

    // Next occupancy and which register each edge loads.
    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_clear) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_next         = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_next         = ONE;
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_next      = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    // Ready is low here, so only the output side can move.
                    if (w_out_xfer) begin
                        w_next           = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next = EMPTY;
                end
            endcase
        end
    end

    // State, registered ready and the two payload registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
            if (w_load_main_in) begin
                r_main <= i_in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_state != EMPTY);
    assign o_out_data  = r_main;
    assign o_out_xfer  = w_out_xfer;

endmodule

// File: rtl/des_swap_stage.sv
// Registered DES final half-block swap with per-block swap select,
// skid buffering for back-pressure and a delivered-block counter.
module des_swap_stage
    import des_pkg::*;
#(
    parameter int unsigned HALF_W = DES_HALF_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [HALF_W-1:0] IN_LEFT,
    input  logic [HALF_W-1:0] IN_RIGHT,
    input  logic              IN_SWAP,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [HALF_W-1:0] OUT_LEFT,
    output logic [HALF_W-1:0] OUT_RIGHT,
    output logic              OUT_SWAPPED,
    output logic [CNT_W-1:0]  BLK_COUNT
);

    localparam int unsigned PAY_W = 2 * HALF_W + 1;

    logic [HALF_W-1:0] w_cap_left;
    logic [HALF_W-1:0] w_cap_right;
    logic [PAY_W-1:0]  w_in_data;
    logic [PAY_W-1:0]  w_out_data;
    logic              w_out_xfer;
    logic [CNT_W-1:0]  r_blk_count;

    // Swap at capture; the select bit travels with the block as its tag.
    assign w_cap_left  = IN_SWAP ? IN_RIGHT : IN_LEFT;
    assign w_cap_right = IN_SWAP ? IN_LEFT  : IN_RIGHT;
    assign w_in_data   = {IN_SWAP, w_cap_left, w_cap_right};

    des_skid_buf #(
        .DATA_W (PAY_W)
    ) u_skid (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_clear     (CLEAR),
        .i_in_valid  (IN_VALID),
        .o_in_ready  (IN_READY),
        .i_in_data   (w_in_data),
        .o_out_valid (OUT_VALID),
        .i_out_ready (OUT_READY),
        .o_out_data  (w_out_data),
        .o_out_xfer  (w_out_xfer)
    );

    assign OUT_SWAPPED = w_out_data[PAY_W-1];
    assign OUT_LEFT    = w_out_data[PAY_W-2:HALF_W];
    assign OUT_RIGHT   = w_out_data[HALF_W-1:0];

    // Count delivered blocks; wraps naturally, untouched by CLEAR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_blk_count <= '0;
        end else if (w_out_xfer) begin
            r_blk_count <= r_blk_count + CNT_W'(1);
        end
    end

    assign BLK_COUNT = r_blk_count;

endmodule

// File: tb/tb_des_swap_stage.sv
// Scoreboard bench for des_swap_stage (counter narrowed to 4 bits).
module tb_des_swap_stage;

    localparam int unsigned HW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_swap = 1'b0;
    logic          out_ready = 1'b0;
    logic [HW-1:0] in_left = '0;
    logic [HW-1:0] in_right = '0;
    logic          in_ready;
    logic          out_valid;
    logic [HW-1:0] out_left;
    logic [HW-1:0] out_right;
    logic          out_swapped;
    logic [CW-1:0] blk_count;

    des_swap_stage #(
        .HALF_W (HW),
        .CNT_W  (CW)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .CLEAR       (clear),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .IN_LEFT     (in_left),
        .IN_RIGHT    (in_right),
        .IN_SWAP     (in_swap),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_LEFT    (out_left),
        .OUT_RIGHT   (out_right),
        .OUT_SWAPPED (out_swapped),
        .BLK_COUNT   (blk_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sw;
        logic [HW-1:0] l;
        logic [HW-1:0] r;
    } blk_t;

    blk_t          sb[$];
    int            occ = 0;
    logic          exp_ready = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    int            checks = 0;
    int            passes = 0;

    // Reset the bench model alongside the DUT.
    task automatic model_reset();
        sb.delete();
        occ       = 0;
        exp_ready = 1'b0;
        exp_cnt   = '0;
    endtask

    // One clock cycle: check outputs at the negedge, update the model from
    // the driven handshakes, then return 1 time unit after the posedge.
    task automatic step();
        logic in_fire;
        logic out_fire;
        blk_t exp;
        blk_t got;
        @(negedge clk);
        checks++;
        if (out_valid !== (occ != 0))
            $display("FAIL out_valid: got %0b expected %0b", out_valid, (occ != 0));
        else passes++;
        checks++;
        if (in_ready !== exp_ready)
            $display("FAIL in_ready: got %0b expected %0b", in_ready, exp_ready);
        else passes++;
        checks++;
        if (blk_count !== exp_cnt)
            $display("FAIL blk_count: got %0d expected %0d", blk_count, exp_cnt);
        else passes++;
        if (occ != 0) begin
            got = {out_swapped, out_left, out_right};
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard: output present but no block expected");
            end else begin
                exp = sb[0];
                if (got !== exp)
                    $display("FAIL out_data: got sw=%0b %h_%h expected sw=%0b %h_%h",
                             got.sw, got.l, got.r, exp.sw, exp.l, exp.r);
                else passes++;
            end
        end
        in_fire  = in_valid && exp_ready && !clear;
        out_fire = (occ != 0) && out_ready && !clear;
        if (out_fire) begin
            if (sb.size() != 0) void'(sb.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
        if (in_fire) begin
            if (in_swap) sb.push_back({1'b1, in_right, in_left});
            else         sb.push_back({1'b0, in_left, in_right});
        end
        if (clear) begin
            sb.delete();
            occ = 0;
        end else begin
            occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
        end
        exp_ready = (occ != 2);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [HW-1:0] l, input logic [HW-1:0] r, input logic sw);
        in_left  = l;
        in_right = r;
        in_swap  = sw;
        in_valid = 1'b1;
    endtask

    // Plain reset used between scenarios.
    task automatic do_reset();
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, in_ready, blk_count} !== '0)
            $display("FAIL reset_ctrl: got v=%0b r=%0b c=%0d expected 0", out_valid, in_ready, blk_count);
        else passes++;
        checks++;
        if ({out_left, out_right, out_swapped} !== '0)
            $display("FAIL reset_data: got %h_%h_%0b expected 0", out_left, out_right, out_swapped);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %0b expected 1", in_ready);
        else passes++;
    endtask

    task automatic test_swap();
        out_ready = 1'b1;
        offer(32'h01234567, 32'h89ABCDEF, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_swapped, out_left, out_right} !== {2'b11, 32'h89ABCDEF, 32'h01234567})
            $display("FAIL swap: got v=%0b sw=%0b %h_%h expected v=1 sw=1 89abcdef_01234567",
                     out_valid, out_swapped, out_left, out_right);
        else passes++;
        step();
        checks++;
        if (blk_count !== 4'd1)
            $display("FAIL swap_count: got %0d expected 1", blk_count);
        else passes++;
    endtask

    task automatic test_pass();
        out_ready = 1'b1;
        offer(32'h01234567, 32'h89ABCDEF, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_swapped, out_left, out_right} !== {2'b10, 32'h01234567, 32'h89ABCDEF})
            $display("FAIL pass: got v=%0b sw=%0b %h_%h expected v=1 sw=0 01234567_89abcdef",
                     out_valid, out_swapped, out_left, out_right);
        else passes++;
        step();
        checks++;
        if (blk_count !== 4'd2)
            $display("FAIL pass_count: got %0d expected 2", blk_count);
        else passes++;
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        offer(32'hA0A0A0A0, 32'hA1A1A1A1, 1'b1);
        step();
        offer(32'hB0B0B0B0, 32'hB1B1B1B1, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL bp_full: in_ready got %0b expected 0", in_ready);
        else passes++;
        offer(32'hC0C0C0C0, 32'hC1C1C1C1, 1'b1);
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL bp_drain: got pending=%0d v=%0b expected 0 0", sb.size(), out_valid);
        else passes++;
    endtask

    task automatic test_stream_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            offer($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (blk_count !== 4'd1)
            $display("FAIL wrap_count: got %0d expected 1", blk_count);
        else passes++;
    endtask

    task automatic test_clear();
        logic [CW-1:0] cnt_before;
        out_ready = 1'b0;
        offer(32'h11111111, 32'h22222222, 1'b0);
        step();
        offer(32'h33333333, 32'h44444444, 1'b1);
        step();
        cnt_before = blk_count;
        out_ready = 1'b1;
        clear = 1'b1;
        offer(32'h55555555, 32'h66666666, 1'b0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || blk_count !== cnt_before)
            $display("FAIL clear_two: got v=%0b r=%0b c=%0d expected v=0 r=1 c=%0d",
                     out_valid, in_ready, blk_count, cnt_before);
        else passes++;
        step();
        // Clear from ONE while ready is high: the offered block must be dropped.
        out_ready = 1'b0;
        offer(32'h77777777, 32'h88888888, 1'b1);
        step();
        clear = 1'b1;
        offer(32'h99999999, 32'hAAAAAAAA, 1'b0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        offer(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        step();
        offer(32'h0BADF00D, 32'hFEEDFACE, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, in_ready, blk_count, out_left, out_right, out_swapped} !== '0)
            $display("FAIL mid_reset: got v=%0b r=%0b c=%0d %h_%h sw=%0b expected all 0",
                     out_valid, in_ready, blk_count, out_left, out_right, out_swapped);
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        offer(32'h12345678, 32'h9ABCDEF0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_swap();
        test_pass();
        test_back_pressure();
        test_stream_wrap();
        test_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/des_swap_stage.md
# des_swap_stage

Parametrised, registered successor to the DES final half-block swap. It accepts a left/right half pair under a valid/ready handshake and either exchanges the halves or passes them straight through, selected per block. It buffers up to two blocks in a skid buffer so that full-rate throughput survives output back-pressure. It sits between the 16th Feistel round and the inverse initial permutation, and also between chained DES cores in the triple-DES datapath, where some stage boundaries must not swap.

## Interface

Parameters:

- HALF_W, 32: width of each half-block in bits.
- CNT_W, 16: width of the delivered-block counter.

Ports:

- CLK  in  1  Single clock; all state updates on the rising edge.
- RST_N  in  1  Reset, asynchronous and active-low.
- CLEAR  in  1  Synchronous flush of buffered blocks.
- IN_VALID  in  1  Input block present.
- IN_READY  out  1  Stage can accept a block (registered).
- IN_LEFT  in  HALF_W  Left half.
- IN_RIGHT  in  HALF_W  Right half.
- IN_SWAP  in  1  1 = exchange halves; 0 = pass through.
- OUT_VALID  out  1  Output block present.
- OUT_READY  in  1  Consumer accepts the block.
- OUT_LEFT  out  HALF_W  Output left half.
- OUT_RIGHT  out  HALF_W  Output right half.
- OUT_SWAPPED  out  1  IN_SWAP value of the block currently on the output.
- BLK_COUNT  out  CNT_W  Number of blocks delivered; wraps at 2^CNT_W.

## Operation

- **Transfers.**
  - An input transfer occurs when IN_VALID and IN_READY are both high at the clock edge.
  - An output transfer occurs when OUT_VALID and OUT_READY are both high at the clock edge.
- **Swap rule.** The swap is applied at capture.
  - IN_SWAP=1: stored left = IN_RIGHT, stored right = IN_LEFT.
  - IN_SWAP=0: stored left = IN_LEFT, stored right = IN_RIGHT.
  - The IN_SWAP bit is stored alongside the block as its tag.
- **Storage.** Two registers: MAIN drives the outputs; SKID holds overflow.
- **States.** EMPTY, ONE (MAIN full), TWO (MAIN and SKID full).
  - EMPTY: input transfer → ONE, block loaded into MAIN.
  - ONE, input only → TWO, block loaded into SKID.
  - ONE, output only → EMPTY.
  - ONE, input and output together → ONE, MAIN reloaded with the new block.
  - TWO: IN_READY is 0, so no input transfer is possible. Output transfer → ONE, SKID moved to MAIN.
- **Ready.** IN_READY is registered and equals (next state != TWO).
- **Ordering.** Strict FIFO; no block is dropped or duplicated except by CLEAR or reset.
- **Outputs.** OUT_VALID = (state != EMPTY). OUT_LEFT, OUT_RIGHT and OUT_SWAPPED come from MAIN and are held stable while OUT_VALID is high and OUT_READY is low.
- **BLK_COUNT.** Increments by 1 on each output transfer and wraps from all-ones to 0. CLEAR does not affect it.
- **CLEAR.** Has priority over every handshake.
  - Next state is EMPTY and IN_READY becomes 1.
  - An input presented in the same cycle is not accepted, even if IN_READY was high.
  - An output handshake in the same cycle is not counted.
- **Reset.**
  - Asynchronous assertion at any time empties the stage immediately.
  - OUT_VALID=0, IN_READY=0, OUT_LEFT=0, OUT_RIGHT=0, OUT_SWAPPED=0, BLK_COUNT=0, state EMPTY.

## Timing

- Latency from input transfer to OUT_VALID is 1 cycle.
- Throughput is one block per cycle with OUT_READY held high.
- IN_READY rises on the first CLK edge after RST_N deasserts.
- IN_READY falls on the edge that enters TWO. It rises on the edge that leaves TWO, i.e. the edge after an output transfer in TWO.
- There is no combinational path from any input to any output.

## Structure

- Shared package des_pkg holds:
  - the default half width constant DES_HALF_W = 32;
  - the state enum swap_state_t {EMPTY, ONE, TWO}.
- The swap mux is two multiplexers and stays inline.
- The two-entry skid buffer is a natural sub-module, des_skid_buf, parametrised on payload width (2*HALF_W+1) and owning the state machine and ready logic. des_swap_stage wraps it with the swap mux and the counter.

## Test plan

1. **Reset.** Hold RST_N low → OUT_VALID=0, IN_READY=0, BLK_COUNT=0. Release RST_N → IN_READY=1 at the first edge.
2. **Swap.** IN_LEFT=32'h01234567, IN_RIGHT=32'h89ABCDEF, IN_SWAP=1, OUT_READY=1 → next cycle OUT_LEFT=32'h89ABCDEF, OUT_RIGHT=32'h01234567, OUT_SWAPPED=1; then BLK_COUNT=1.
3. **Pass-through.** Same data with IN_SWAP=0 → OUT_LEFT=32'h01234567, OUT_RIGHT=32'h89ABCDEF, OUT_SWAPPED=0.
4. **Back-pressure.** OUT_READY=0 with blocks A, B, C offered back-to-back → A and B accepted and IN_READY=0 after B. Raise OUT_READY → outputs A, B, C in order, C accepted one cycle after A leaves, with no bubble after.
5. **Streaming and wrap.** With CNT_W=4, stream 17 blocks with OUT_READY=1 → one output per cycle, BLK_COUNT=1 at the end.
6. **CLEAR and mid-operation reset.**
   - In state TWO, pulse CLEAR while IN_VALID=1 → next cycle OUT_VALID=0, IN_READY=1, the offered block is absent from the output, BLK_COUNT unchanged.
   - Repeat the same setup asserting RST_N instead → all outputs 0 immediately.
